// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: reset PC, bus widths and bus layouts.
// Used by if_stage and, when IF_INST_BUF_EN is defined, by if_inst_buf.
package if_stage_pkg;

  localparam logic [31:0] PC_RESET       = 32'h1C00_0000;
  localparam int          IF_TO_ID_BUS_W = 64;
  localparam int          ID_TO_IF_BUS_W = 33;
  localparam int          INST_W         = 32;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } if_to_id_t;

  typedef struct packed {
    logic        br_taken;
    logic [31:0] br_target;
  } id_to_if_t;

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_inst_buf.sv
// Holding register for the fetched word while ID stalls, so the stage works with SRAMs
// whose output changes while the read enable is low. Only instantiated under IF_INST_BUF_EN.
module if_inst_buf
  import if_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic              clear,
  input  logic [INST_W-1:0] rdata,
  output logic              buf_valid,
  output logic [INST_W-1:0] buf_inst
);

  // Capture once per stall; a handshake or redirect frees the buffer again.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      buf_valid <= 1'b0;
      buf_inst  <= '0;
    end else if (capture && !buf_valid) begin
      buf_valid <= 1'b1;
      buf_inst  <= rdata;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC selection, instruction SRAM request and the IF->ID holding slot.
// Optional feature macro: IF_INST_BUF_EN adds a stall buffer for the fetched instruction.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ID_allow_in,
  output logic                      IF_to_ID_valid,
  output logic [IF_TO_ID_BUS_W-1:0] IF_to_ID_bus,
  input  logic [ID_TO_IF_BUS_W-1:0] ID_to_IF_bus,
  output logic                      inst_sram_en,
  output logic [3:0]                inst_sram_we,
  output logic [31:0]               inst_sram_addr,
  output logic [31:0]               inst_sram_wdata,
  input  logic [INST_W-1:0]         inst_sram_rdata
);

  id_to_if_t         br_bus;
  if_to_id_t         out_bus;
  logic              br_taken;
  logic [31:0]       br_target;
  logic              fs_valid;
  logic [31:0]       fs_pc;
  logic              br_pending;
  logic [31:0]       br_target_r;
  logic              fs_ready_go;
  logic              fs_allow_in;
  logic [31:0]       nextpc;
  logic [INST_W-1:0] fs_inst;

  assign br_bus    = id_to_if_t'(ID_to_IF_bus);
  assign br_taken  = br_bus.br_taken;
  assign br_target = br_bus.br_target;

  assign fs_ready_go = 1'b1;
  assign fs_allow_in = !fs_valid || (fs_ready_go && ID_allow_in);

  // A live redirect beats a parked one, which beats sequential fetch.
  always_comb begin
    nextpc = seq_pc(fs_pc);
    if (br_taken) begin
      nextpc = br_target;
    end else if (br_pending) begin
      nextpc = br_target_r;
    end
  end

  // A redirect that cannot be taken now is parked and the wrong-path slot is emptied,
  // which reopens fs_allow_in so the parked target is fetched on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid    <= 1'b0;
      fs_pc       <= RESET_PC - 32'd4;
      br_pending  <= 1'b0;
      br_target_r <= '0;
    end else if (fs_allow_in) begin
      fs_valid    <= 1'b1;
      fs_pc       <= nextpc;
      br_pending  <= 1'b0;
    end else if (br_taken) begin
      fs_valid    <= 1'b0;
      br_pending  <= 1'b1;
      br_target_r <= br_target;
    end
  end

`ifdef IF_INST_BUF_EN
  logic              buf_valid;
  logic [INST_W-1:0] buf_inst;

  if_inst_buf u_inst_buf (
    .clk       (clk),
    .reset     (reset),
    .capture   (fs_valid && !ID_allow_in),
    .clear     ((fs_valid && ID_allow_in) || br_taken),
    .rdata     (inst_sram_rdata),
    .buf_valid (buf_valid),
    .buf_inst  (buf_inst)
  );

  assign fs_inst = buf_valid ? buf_inst : inst_sram_rdata;
`else
  assign fs_inst = inst_sram_rdata;
`endif

  assign inst_sram_en    = !reset && fs_allow_in;
  assign inst_sram_we    = 4'b0000;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'b0;

  assign out_bus.pc     = fs_pc;
  assign out_bus.inst   = fs_inst;
  assign IF_to_ID_bus   = out_bus;
  assign IF_to_ID_valid = fs_valid && !br_taken;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed pipeline scenarios followed by random
// stall/redirect/reset traffic, compared against a fetch-stream reference model.
module tb_if_stage;
  import if_stage_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      ID_allow_in;
  logic                      IF_to_ID_valid;
  logic [IF_TO_ID_BUS_W-1:0] IF_to_ID_bus;
  logic [ID_TO_IF_BUS_W-1:0] ID_to_IF_bus;
  logic                      inst_sram_en;
  logic [3:0]                inst_sram_we;
  logic [31:0]               inst_sram_addr;
  logic [31:0]               inst_sram_wdata;
  logic [INST_W-1:0]         inst_sram_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what the stage holds and which address it fetches next.
  logic        model_ok     = 1'b0;
  logic        m_held_valid = 1'b0;
  logic [31:0] m_held_pc    = '0;
  logic [31:0] m_next_fetch = '0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ID_allow_in     (ID_allow_in),
    .IF_to_ID_valid  (IF_to_ID_valid),
    .IF_to_ID_bus    (IF_to_ID_bus),
    .ID_to_IF_bus    (ID_to_IF_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Synchronous SRAM; with the buffer enabled its output is scrambled while not enabled.
  always @(posedge clk) begin
    if (inst_sram_en) begin
      inst_sram_rdata <= memWord(inst_sram_addr);
    end
`ifdef IF_INST_BUF_EN
    else begin
      inst_sram_rdata <= $urandom();
    end
`endif
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic allow, input logic br, input logic [31:0] tgt);
    logic        fetch;
    logic [31:0] exp_addr;
    @(negedge clk);
    reset        = rst;
    ID_allow_in  = allow;
    ID_to_IF_bus = {br, tgt};
    #1;
    fetch    = !m_held_valid || allow;
    exp_addr = br ? tgt : m_next_fetch;
    if (model_ok) begin
      checkOutput("sram_en", 64'(inst_sram_en), 64'(!rst && fetch));
      checkOutput("sram_addr", 64'(inst_sram_addr), 64'(exp_addr));
      checkOutput("sram_we", 64'(inst_sram_we), 64'd0);
      checkOutput("sram_wdata", 64'(inst_sram_wdata), 64'd0);
      checkOutput("valid", 64'(IF_to_ID_valid), 64'(m_held_valid && !br));
      checkOutput("bus_pc", 64'(IF_to_ID_bus[63:32]), 64'(m_held_pc));
      if (m_held_valid) begin
        checkOutput("bus_inst", 64'(IF_to_ID_bus[31:0]), 64'(memWord(m_held_pc)));
      end
    end
    @(posedge clk);
    if (rst) begin
      model_ok     = 1'b1;
      m_held_valid = 1'b0;
      m_held_pc    = PC_RESET - 32'd4;
      m_next_fetch = PC_RESET;
    end else if (fetch) begin
      m_held_valid = 1'b1;
      m_held_pc    = exp_addr;
      m_next_fetch = exp_addr + 32'd4;
    end else if (br) begin
      m_held_valid = 1'b0;
      m_next_fetch = tgt;
    end
  endtask

  initial begin
    logic        r_rst;
    logic        r_allow;
    logic        r_br;
    logic [31:0] r_tgt;
    reset        = 1'b1;
    ID_allow_in  = 1'b1;
    ID_to_IF_bus = '0;

    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    // Sequential fetch from reset.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    // Three-cycle ID stall holding pc 0x1C000008.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    // Redirect while IF can accept.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h1C00_0100);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    // Redirect while ID stalls, then the parked target is fetched.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1C00_0200);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    // A new redirect overrides a parked one.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1C00_0300);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1C00_0400);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    // Reset while a redirect is parked.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1C00_0500);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 500; i++) begin
      r_rst   = ($urandom_range(0, 80) == 0);
      r_allow = ($urandom_range(0, 3) != 0);
      r_br    = ($urandom_range(0, 5) == 0);
      r_tgt   = 32'h1C00_0000 + (32'($urandom_range(0, 1023)) << 2);
      applyStimulus(r_rst, r_allow, r_br, r_tgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
